// File: rtl/fetch_stage.sv
// RV32I instruction-fetch stage: owns the PC, drives a req/ack imem port and the IF/ID register.
// Optional misaligned-redirect trap enabled by defining FETCH_MISALIGN_CHECK_EN.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        b_taken,
  input  logic [31:0] b_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_inst,
  output logic        if_id_valid
`ifdef FETCH_MISALIGN_CHECK_EN
  ,
  output logic        fetch_fault
`endif
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_BUF   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] pc_inc;
  logic [31:0] tgt;
  logic [31:0] buf_pc;
  logic [31:0] buf_inst;
  logic [31:0] redir_pc;
  logic [31:0] drain_pc;
  logic        ack_live;
  logic        bad_redir;
  logic        halt_pend;
  logic        halt_now;

  // An ack is only meaningful while a request is actually on the bus.
  assign ack_live  = imem_ack & imem_req;
  assign pc_inc    = pc + 32'd4;
  assign imem_addr = pc;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign redir_pc  = b_pc;
  assign bad_redir = b_taken & (b_pc[1:0] != 2'b00);
`else
  assign redir_pc  = b_pc & 32'hFFFF_FFFC;
  assign bad_redir = 1'b0;
`endif

  // A redirect arriving in the same cycle as the drained ack supersedes tgt.
  assign drain_pc = b_taken ? redir_pc : tgt;
  assign halt_now = halt_pend | bad_redir;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_FETCH;
      pc          <= RESET_PC;
      imem_req    <= 1'b0;
      if_id_pc    <= 32'h0000_0000;
      if_id_inst  <= NOP_INST;
      if_id_valid <= 1'b0;
      halt_pend   <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (b_taken) begin
            if_id_valid <= 1'b0;
            if_id_inst  <= NOP_INST;
            if (ack_live || !imem_req) begin
              if (bad_redir) begin
                state    <= S_HALT;
                imem_req <= 1'b0;
              end else begin
                pc       <= redir_pc;
                imem_req <= 1'b1;
              end
            end else begin
              state     <= S_DRAIN;
              imem_req  <= 1'b1;
              halt_pend <= bad_redir;
            end
          end else if (ack_live) begin
            pc <= pc_inc;
            if (stall) begin
              state    <= S_BUF;
              imem_req <= 1'b0;
            end else begin
              if_id_pc    <= pc;
              if_id_inst  <= imem_data;
              if_id_valid <= 1'b1;
              imem_req    <= 1'b1;
            end
          end else begin
            imem_req <= 1'b1;
            if (!stall) begin
              if_id_valid <= 1'b0;
              if_id_inst  <= NOP_INST;
            end
          end
        end

        S_BUF: begin
          if (b_taken) begin
            if_id_valid <= 1'b0;
            if_id_inst  <= NOP_INST;
            if (bad_redir) begin
              state <= S_HALT;
            end else begin
              state    <= S_FETCH;
              pc       <= redir_pc;
              imem_req <= 1'b1;
            end
          end else if (!stall) begin
            if_id_pc    <= buf_pc;
            if_id_inst  <= buf_inst;
            if_id_valid <= 1'b1;
            state       <= S_FETCH;
            imem_req    <= 1'b1;
          end
        end

        S_DRAIN: begin
          if (b_taken) begin
            halt_pend <= halt_now;
          end
          if (ack_live) begin
            if (halt_now) begin
              state    <= S_HALT;
              imem_req <= 1'b0;
            end else begin
              state    <= S_FETCH;
              pc       <= drain_pc;
              imem_req <= 1'b1;
            end
          end
        end

        default: begin
          imem_req    <= 1'b0;
          if_id_valid <= 1'b0;
          if_id_inst  <= NOP_INST;
        end
      endcase
    end
  end

  // Datapath-only storage: meaningful only in the states that read it.
  always_ff @(posedge clk) begin
    if (b_taken && ((state == S_FETCH) || (state == S_DRAIN))) begin
      tgt <= redir_pc;
    end
    if ((state == S_FETCH) && !b_taken && ack_live && stall) begin
      buf_pc   <= pc;
      buf_inst <= imem_data;
    end
  end

`ifdef FETCH_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_fault <= 1'b0;
    end else if (bad_redir) begin
      fetch_fault <= 1'b1;
    end
  end
`endif

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
Instruction-fetch stage of the 5-stage RV32I pipeline, and the producer side of the IF/ID interface that decode consumes. It owns the PC, issues requests on a req/ack instruction-memory port, and drives if_id_pc, if_id_inst and if_id_valid. It accepts branch redirects (b_taken, b_pc) back from decode, and holds IF/ID under a stall from the hazard unit.

Parameters:
RESET_PC, 32'h0000_0000, PC fetched first after reset
NOP_INST, 32'h0000_0013, instruction (addi x0,x0,0) driven on if_id_inst when flushed/empty

Ports:
clk  in  1  pipeline clock, all state updates on posedge
rst  in  1  synchronous reset, active-high
b_taken  in  1  redirect request from decode, sampled at posedge
b_pc  in  32  redirect target, valid with b_taken
stall  in  1  hold IF/ID contents (hazard unit)
imem_req  out  1  fetch request
imem_addr  out  32  fetch address, word aligned
imem_ack  in  1  memory completes request; imem_data valid same cycle
imem_data  in  32  fetched instruction
if_id_pc  out  32  PC of instruction in IF/ID
if_id_inst  out  32  instruction in IF/ID
if_id_valid  out  1  IF/ID holds a live instruction

Behaviour:
- Reset, while rst is high at posedge:
  - pc=RESET_PC; state=FETCH.
  - if_id_pc=0; if_id_inst=NOP_INST; if_id_valid=0.
  - Buffer empty; imem_req=0 during the reset cycle.
- A reset mid-transaction abandons it. The memory must tolerate req falling without ack.
- Memory protocol:
  - imem_req and imem_addr are registered.
  - imem_addr is held stable while imem_req=1 until a posedge samples imem_ack=1.
  - imem_ack with imem_req=0 is ignored.
  - Zero-wait memories may ack in the first req cycle; this gives one instruction per cycle.
- States:
  - FETCH: imem_req=1, imem_addr=pc.
  - BUFFERED: imem_req=0; one fetched instruction sits in the skid buffer.
  - DRAIN: imem_req=1, imem_addr=old pc; the outstanding response will be discarded; redirect target held in tgt.
- FETCH transitions:
  - ack, no stall, no b_taken: IF/ID <= {pc, imem_data, valid=1}; pc <= pc+4; stay.
  - ack & stall, no b_taken: buffer <= {pc, imem_data}; pc <= pc+4; -> BUFFERED. IF/ID holds.
  - No ack, no b_taken: IF/ID holds if stall. Otherwise if_id_valid <= 0 and if_id_inst <= NOP_INST (bubble).
- BUFFERED transitions:
  - stall=0: IF/ID <= buffer, valid=1; -> FETCH at pc.
  - stall=1: hold.
- b_taken takes priority over stall and ack in all states:
  - IF/ID is flushed (valid=0, inst=NOP_INST, pc unchanged); buffer is cleared.
  - FETCH with ack, or BUFFERED: data is discarded; pc <= b_pc; -> FETCH.
  - FETCH without ack: tgt <= b_pc; -> DRAIN.
  - DRAIN: tgt <= b_pc (latest redirect wins).
- DRAIN transitions:
  - On ack: data is discarded; pc <= tgt; -> FETCH.
  - IF/ID stays invalid throughout DRAIN.
- Arithmetic: pc+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0. No instruction is lost or duplicated across stall or wait-state boundaries.
- Outputs are registered; there is no combinational path from inputs to outputs.

Optional Feature:
Macro: FETCH_MISALIGN_CHECK_EN.
- Enabled:
  - Adds output fetch_fault (1 bit, reset 0).
  - A b_taken with b_pc[1:0]!=0 sets fetch_fault, sticky until rst. It flushes IF/ID as usual, then enters state HALT: imem_req=0, IF/ID invalid, until reset.
  - If a request is outstanding, it first completes it (DRAIN semantics), then enters HALT.
- Disabled: there is no fetch_fault port, and b_pc[1:0] is forced to 2'b00 on capture.

Test Plan:
1. Zero-wait memory, ack every cycle, imem_data=addr^32'hA5A5_0000, rst released -> imem_addr 0,4,8,... on consecutive cycles. if_id_pc 0,4,8 with matching inst one cycle after each ack; valid stays 1.
2. Ack delayed 3 cycles per request -> imem_addr=0 stable for 3 req cycles. IF/ID gets exactly one instruction per ack; valid=0 in the gap cycles.
3. Stall=1 for 2 cycles coincident with ack at addr 8 -> IF/ID holds pc=4, req drops, BUFFERED. After stall falls, if_id_pc=8, then fetch resumes at 12; no duplicate, no loss.
4. b_taken=1, b_pc=32'h100 while the request at 8 awaits ack -> req/addr held at 8 until ack, response discarded, next imem_addr=32'h100. if_id_valid=0 from the redirect until the first instruction from 0x100.
5. b_taken and stall in the same cycle in BUFFERED -> buffer cleared, IF/ID flushed, next imem_addr=b_pc.
6. RESET_PC=32'hFFFF_FFFC -> second fetch address is 32'h0000_0000. With FETCH_MISALIGN_CHECK_EN, b_pc=32'h102 -> fetch_fault=1, imem_req stays 0 until rst.
